// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings for the arbiter, bus interface, drivers and
// monitors.
//   htrans_e     : transfer types (IDLE, BUSY, NONSEQ, SEQ)
//   hburst_e     : burst types (SINGLE .. INCR16)
//   HRESP_*      : slave response codes
//   arb_state_e  : arbiter diagnostic states
//   burst_beats  : number of beats in a burst type (INCR counts as 1)
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  localparam int HRESP_OKAY  = 0;
  localparam int HRESP_ERROR = 1;

  typedef enum logic [1:0] {
    ST_PARK  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_BURST = 2'd2,
    ST_LOCK  = 2'd3
  } arb_state_e;

  // Undefined-length INCR is treated like a single beat: it is never protected
  // against a grant change and the master restarts with NONSEQ if cut short.
  function automatic logic [4:0] burst_beats(input hburst_e b);
    case (b)
      WRAP4, INCR4:   return 5'd4;
      WRAP8, INCR8:   return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   in  NM  request vector
//   last  in  MW  index of the most recent grant
//   grant out NM  one-hot pick: first requester scanning upward from last+1,
//                 wrapping; all zero when nobody requests
//   valid out 1   at least one requester present
module rr_pick #(
  parameter int NM = 4,
  parameter int MW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [MW-1:0] last,
  output logic [NM-1:0] grant,
  output logic          valid
);

  int pos;

  // The last owner is scanned last, so it only wins again when it is alone.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = 1; k <= NM; k++) begin
      pos = (int'(last) + k) % NM;
      if (!valid && req[pos]) begin
        grant[pos] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with burst and lock protection.
//   hclk         in  1   bus clock
//   hreset       in  1   synchronous active-high reset
//   hbusreq      in  NM  per-master bus request
//   hlock        in  NM  per-master locked-transfer request
//   htrans       in  2   address-phase transfer type of the current owner
//   hburst       in  3   address-phase burst type of the current owner
//   hready       in  1   phase advance; arbitration only on hready=1 edges
//   hresp        in  RW  slave response
//   hgrant       out NM  one-hot grant
//   hmaster      out MW  address-phase owner
//   hmaster_data out MW  data-phase owner (hmaster delayed one handover)
//   hmastlock    out 1   current address phase is locked
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NM         = 4,
  parameter int DEF_MASTER = 0,
  parameter int RW         = 2,
  parameter int MW         = $clog2(NM)
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic [NM-1:0] hbusreq,
  input  logic [NM-1:0] hlock,
  input  logic [1:0]    htrans,
  input  logic [2:0]    hburst,
  input  logic          hready,
  input  logic [RW-1:0] hresp,
  output logic [NM-1:0] hgrant,
  output logic [MW-1:0] hmaster,
  output logic [MW-1:0] hmaster_data,
  output logic          hmastlock
);

  logic [NM-1:0] hgrant_reg, hgrant_next;
  logic [MW-1:0] hmaster_reg, hmaster_data_reg;
  logic [MW-1:0] last_grant_reg, last_grant_next;
  logic [MW-1:0] owner_idx;
  logic          hmastlock_reg, hmastlock_next;
  logic [4:0]    cnt_reg, cnt_next;
  arb_state_e    state_reg, state_next;
  logic [NM-1:0] pick_grant;
  logic          pick_valid;
  logic          err, lock_hold, arb_ok;

  function automatic logic [MW-1:0] onehot_idx(input logic [NM-1:0] oh);
    logic [MW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NM; i++) begin
      if (oh[i]) idx = MW'(i);
    end
    return idx;
  endfunction

  rr_pick #(.NM(NM), .MW(MW)) u_pick (
    .req   (hbusreq),
    .last  (last_grant_reg),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign owner_idx = onehot_idx(hgrant_reg);
  assign err       = (hresp == RW'(HRESP_ERROR));
  assign lock_hold = hmastlock_reg & hlock[hmaster_reg];
  // cnt_next <= 1 lets the grant move one beat early so the next owner's
  // NONSEQ follows the last beat without an idle cycle.
  assign arb_ok    = hready & (cnt_next <= 5'd1) & ~lock_hold;

  // Remaining-beat counter; frozen while hready is low.
  always_comb begin
    cnt_next = cnt_reg;
    if (hready) begin
      if (err) begin
        cnt_next = 5'd0;
      end else if (htrans == NONSEQ) begin
        cnt_next = burst_beats(hburst_e'(hburst)) - 5'd1;
      end else if (htrans == SEQ && cnt_reg != 5'd0) begin
        cnt_next = cnt_reg - 5'd1;
      end
    end
  end

  always_comb begin
    hgrant_next     = hgrant_reg;
    last_grant_next = last_grant_reg;
    if (arb_ok) begin
      hgrant_next     = pick_valid ? pick_grant : (NM'(1) << DEF_MASTER);
      last_grant_next = onehot_idx(hgrant_next);
    end
    hmastlock_next = hready ? (hlock[owner_idx] & hbusreq[owner_idx]) : hmastlock_reg;
  end

  // Diagnostic state tracker; it observes the datapath and drives nothing.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_PARK:  if (|hbusreq) state_next = ST_OPEN;
      ST_OPEN: begin
        if (arb_ok && !(|hbusreq))
          state_next = ST_PARK;
        else if (hready && !err && htrans == NONSEQ && cnt_next > 5'd1)
          state_next = ST_BURST;
      end
      ST_BURST: if (hready && cnt_next <= 5'd1) state_next = ST_OPEN;
      ST_LOCK:  if (!hlock[hmaster_reg]) state_next = ST_OPEN;
      default:  state_next = ST_PARK;
    endcase
    if (hmastlock_next && !hmastlock_reg) state_next = ST_LOCK;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      hgrant_reg       <= NM'(1) << DEF_MASTER;
      hmaster_reg      <= MW'(DEF_MASTER);
      hmaster_data_reg <= MW'(DEF_MASTER);
      last_grant_reg   <= MW'(DEF_MASTER);
      hmastlock_reg    <= 1'b0;
      cnt_reg          <= 5'd0;
      state_reg        <= ST_PARK;
    end else begin
      hgrant_reg     <= hgrant_next;
      last_grant_reg <= last_grant_next;
      hmastlock_reg  <= hmastlock_next;
      cnt_reg        <= cnt_next;
      state_reg      <= state_next;
      if (hready) begin
        hmaster_reg      <= owner_idx;
        hmaster_data_reg <= hmaster_reg;
      end
    end
  end

  assign hgrant       = hgrant_reg;
  assign hmaster      = hmaster_reg;
  assign hmaster_data = hmaster_data_reg;
  assign hmastlock    = hmastlock_reg;

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin bus arbiter for a multi-master AHB system: it decides which of NM masters owns the shared address/data bus and drives the grant and owner-select signals. The address/data multiplexers and the slaves sit behind it. It keeps each fixed-length burst and each locked sequence with one master, and parks the bus on a default master when no one requests.

## Interface
- NM, 4, number of masters (2..8)
- DEF_MASTER, 0, park/default master index
- RW, 2, hresp width
- MW, $clog2(NM), master index width
- hclk  in  1  bus clock; one clock; every register updates on posedge hclk
- hreset  in  1  reset, synchronous and active-high
- hbusreq  in  NM  per-master bus request
- hlock  in  NM  per-master locked-transfer request
- htrans  in  2  muxed address-phase transfer type (current owner)
- hburst  in  3  muxed address-phase burst type
- hready  in  1  transfer done / phase advance
- hresp  in  RW  muxed slave response
- hgrant  out  NM  one-hot grant
- hmaster  out  MW  address-phase owner (address/control mux select)
- hmaster_data  out  MW  data-phase owner (hwdata mux select)
- hmastlock  out  1  current address phase is locked

## Operation
- Arbitration only happens on an edge where hready=1 ("handover edge"). With hready=0, all state holds, including the beat counter.
- cnt is the remaining-beats counter. It is 5-bit and lives in the address phase.
  - On a handover edge with htrans=NONSEQ, cnt_next = beats(hburst) - 1: SINGLE/INCR→0, x4→3, x8→7, x16→15.
  - With htrans=SEQ and cnt>0: cnt_next = cnt-1.
  - With IDLE or BUSY: cnt_next = cnt.
  - If hresp=ERROR (2'b01): cnt_next = 0.
- arb_ok = handover edge AND cnt_next ≤ 1 AND NOT lock_hold.
  - lock_hold = hmastlock=1 AND hlock[hmaster]=1.
  - The grant therefore moves one beat before the burst ends. The next master starts with no idle bubble.
- When arb_ok holds, hgrant is loaded with the pick.
  - The pick is the first requester found scanning from index (last_grant+1) mod NM upward, with wrap-around.
  - A master that is still requesting is therefore re-granted only if no other master requests.
  - No requesters → grant DEF_MASTER (park).
- On every handover edge:
  - hmaster ← index(hgrant)
  - hmaster_data ← hmaster
  - hmastlock ← hlock[index(hgrant)] AND hbusreq[index(hgrant)]
- An INCR (undefined-length) burst can be cut short by a grant change. The master must then restart with NONSEQ.
- FSM, diagnostic, exported only through behaviour:
  - States: PARK (no request, DEF_MASTER granted), OPEN (cnt_next≤1, arbitration allowed), BURST (cnt_next>1), LOCK (lock_hold).
  - PARK→OPEN on any hbusreq.
  - OPEN→BURST on a fixed-burst NONSEQ.
  - BURST→OPEN when cnt_next≤1 or on ERROR.
  - any→LOCK when hmastlock rises.
  - LOCK→OPEN when hlock of the owner drops.
  - OPEN→PARK when there are no requests at arb_ok.
- Simultaneous events:
  - ERROR during a locked burst: cnt clears, but the lock still holds the grant.
  - Request deasserted mid-burst: ignored until the burst finishes.

## Timing
- Reset (hreset=1 at an edge):
  - hgrant = 1<<DEF_MASTER
  - hmaster = hmaster_data = DEF_MASTER
  - hmastlock = 0, cnt = 0, last_grant = DEF_MASTER
  - FSM in PARK
- Reset mid-burst abandons the burst immediately. There is no completion.
- Request→grant latency: hbusreq seen at handover edge N (with arb_ok) → hgrant at N (visible the cycle after) → hmaster at the next handover edge N+1.
- hmaster_data lags hmaster by exactly one handover edge.
- All outputs are registered. There are no combinational input→output paths.

## Structure
- Package ahb_pkg holds:
  - htrans_e (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
  - hburst_e (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
  - hresp codes (OKAY=0, ERROR=1)
  - function burst_beats(hburst_e)
  - shared with the interface, driver and monitor.
- Sub-module rr_pick (NM-wide round-robin picker: req, last index → one-hot grant, valid). It is purely combinational. The arbiter owns all registers.

## Test plan
- Reset, no requests:
  - hgrant=4'b0001, hmaster=0, hmaster_data=0, hmastlock=0.
  - These values stay stable for 20 cycles.
- Rotation:
  - hbusreq=4'b1111, SINGLE NONSEQ each turn, hready=1 → hmaster sequence 1,2,3,0,1.
  - hmaster_data is the same sequence delayed one cycle.
- Fixed burst:
  - Master 2 issues INCR4 while master 3 requests → hgrant switches to 3 on the edge accepting the 3rd beat.
  - hmaster=3 on the cycle after the 4th beat. No IDLE gap.
- Wait states: hready=0 for 3 cycles mid-INCR8 → cnt, hgrant and hmaster all frozen, and the burst resumes correctly.
- Lock: master 1 asserts hlock for 2 INCR4 bursts while master 0 requests → no grant change until hlock drops, then hgrant=4'b0001.
- ERROR and reset:
  - hresp=ERROR on beat 2 of INCR16 → grant moves to the next requester at that handover edge.
  - hreset mid-INCR8 → reset values on the next cycle.
